// File: rtl/im_pkg.sv
// Shared instruction-memory definitions used by both the loader (writer)
// and the IM read path, so both derive word addresses identically.
package im_pkg;

    localparam int unsigned IM_WORDS         = 8192;
    localparam int unsigned IM_ADDR_W        = 13;
    localparam logic [31:0] IM_START_ADDRESS = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN  = 3'd1,
        DATA = 3'd2,
        SUM  = 3'd3,
        DONE = 3'd4,
        ERR  = 3'd5
    } im_load_state_e;

    // Byte address inside the IM window -> RAM word address.
    function automatic logic [IM_ADDR_W-1:0] im_word_addr(input logic [31:0] byte_addr);
        logic [31:0] offs;
        offs = byte_addr - IM_START_ADDRESS;
        return offs[IM_ADDR_W+1:2];
    endfunction

endpackage

// File: rtl/im_word_packer.sv
// Assembles four bytes, first byte most significant, into one 32-bit word.
// word_valid_o is combinational with the 4th byte so the caller can register it.
import im_pkg::*;

module im_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_data_i,
    output logic        word_valid_o,
    output logic [31:0] word_data_o
);

    logic [1:0]  lane_q, lane_d;
    // Only the first three bytes need storing; the 4th is taken straight from the input.
    logic [23:0] shift_q, shift_d;

    always_comb begin
        lane_d  = lane_q;
        shift_d = shift_q;
        if (clear_i) begin
            lane_d  = '0;
            shift_d = '0;
        end else if (byte_valid_i) begin
            lane_d  = lane_q + 2'd1;
            shift_d = {shift_q[15:0], byte_data_i};
        end
    end

    assign word_valid_o = byte_valid_i && (lane_q == 2'd3) && !clear_i;
    assign word_data_o  = {shift_q, byte_data_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q  <= '0;
            shift_q <= '0;
        end else begin
            lane_q  <= lane_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/im_loader.sv
// Instruction-memory loader: parses an N / data / checksum frame, writes
// words through the IM write port and holds the CPU until the load verifies.
import im_pkg::*;

module im_loader #(
    parameter int unsigned IM_WORDS       = im_pkg::IM_WORDS,
    parameter int unsigned LOAD_BASE_WORD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [7:0]           in_data,
    output logic                 in_ready,
    output logic [3:0]           im_we,
    output logic [IM_ADDR_W-1:0] im_addr,
    output logic [31:0]          im_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic                 cpu_hold,
    output logic [13:0]          words_written
);

    im_load_state_e       state_q, state_d;
    logic [13:0]          n_q, n_d;
    logic [13:0]          words_q, words_d;
    logic [31:0]          sum_q, sum_d;
    logic [3:0]           we_q, we_d;
    logic [IM_ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic                 hold_q, hold_d;

    logic        busy_w;
    logic        accept;
    logic        pk_clear;
    logic        word_valid;
    logic [31:0] word;
    logic [32:0] len_end;

    assign busy_w = (state_q == LEN) || (state_q == DATA) || (state_q == SUM);
    assign accept = in_valid && busy_w;

    im_word_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (pk_clear),
        .byte_valid_i (accept),
        .byte_data_i  (in_data),
        .word_valid_o (word_valid),
        .word_data_o  (word)
    );

    // 33-bit so that an N close to 2^32 cannot wrap past the capacity check.
    assign len_end = {1'b0, word} + 33'(LOAD_BASE_WORD);

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        words_d  = words_q;
        sum_d    = sum_q;
        we_d     = '0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        done_d   = done_q;
        error_d  = error_q;
        hold_d   = hold_q;
        pk_clear = 1'b0;

        unique case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d  = LEN;
                    pk_clear = 1'b1;
                    done_d   = 1'b0;
                    error_d  = 1'b0;
                    words_d  = '0;
                    sum_d    = '0;
                    hold_d   = 1'b1;
                end
            end
            LEN: begin
                if (word_valid) begin
                    if (len_end > 33'(IM_WORDS)) begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end else if (word == '0) begin
                        state_d = SUM;
                    end else begin
                        state_d = DATA;
                        n_d     = word[13:0];
                    end
                end
            end
            DATA: begin
                if (word_valid) begin
                    we_d    = '1;
                    addr_d  = IM_ADDR_W'(LOAD_BASE_WORD) + words_q[IM_ADDR_W-1:0];
                    wdata_d = word;
                    sum_d   = sum_q + word;
                    words_d = words_q + 14'd1;
                    if (words_q + 14'd1 == n_q) begin
                        state_d = SUM;
                    end
                end
            end
            SUM: begin
                if (word_valid) begin
                    if (word == sum_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= '0;
            words_q <= '0;
            sum_q   <= '0;
            we_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            words_q <= words_d;
            sum_q   <= sum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            error_q <= error_d;
            hold_q  <= hold_d;
        end
    end

    assign in_ready      = busy_w;
    assign busy          = busy_w;
    assign im_we         = we_q;
    assign im_addr       = addr_q;
    assign im_wdata      = wdata_q;
    assign done          = done_q;
    assign error         = error_q;
    assign cpu_hold      = hold_q;
    assign words_written = words_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: base-0 instance for framing/checksum/reset
// cases, and a base-8190 instance for capacity limits.
module tb_im_loader;

    logic clk;
    logic rst_n;

    logic        start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, busy, done, error, cpu_hold;
    logic [3:0]  im_we;
    logic [12:0] im_addr;
    logic [31:0] im_wdata;
    logic [13:0] words_written;

    logic        b_start, b_in_valid;
    logic [7:0]  b_in_data;
    logic        b_in_ready, b_busy, b_done, b_error, b_cpu_hold;
    logic [3:0]  b_im_we;
    logic [12:0] b_im_addr;
    logic [31:0] b_im_wdata;
    logic [13:0] b_words_written;

    int n_cmp = 0;
    int n_bad = 0;

    logic [12:0] wa [16];
    logic [31:0] wd [16];
    int          wr_cnt = 0;
    logic [12:0] b_wa [16];
    logic [31:0] b_wd [16];
    int          b_wr_cnt = 0;

    im_loader #(.IM_WORDS(8192), .LOAD_BASE_WORD(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold),
        .words_written(words_written)
    );

    im_loader #(.IM_WORDS(8192), .LOAD_BASE_WORD(8190)) dut_hi (
        .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid), .in_data(b_in_data),
        .in_ready(b_in_ready), .im_we(b_im_we), .im_addr(b_im_addr), .im_wdata(b_im_wdata),
        .busy(b_busy), .done(b_done), .error(b_error), .cpu_hold(b_cpu_hold),
        .words_written(b_words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log, sampled 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (im_we !== 4'h0) begin
            n_cmp++;
            if (im_we !== 4'hF) begin n_bad++; $display("FAIL we_encoding got=%h exp=f", im_we); end
            if (wr_cnt < 16) begin wa[wr_cnt] = im_addr; wd[wr_cnt] = im_wdata; end
            wr_cnt++;
        end
        if (b_im_we !== 4'h0) begin
            if (b_wr_cnt < 16) begin b_wa[b_wr_cnt] = b_im_addr; b_wd[b_wr_cnt] = b_im_wdata; end
            b_wr_cnt++;
        end
    end

    task automatic send_byte(input bit s, input logic [7:0] b);
        if (s) begin b_in_valid = 1'b1; b_in_data = b; end
        else   begin in_valid = 1'b1;   in_data = b;   end
        @(negedge clk);
        in_valid   = 1'b0;
        b_in_valid = 1'b0;
    endtask

    task automatic send_word(input bit s, input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(s, w[8*i +: 8]);
    endtask

    task automatic pulse_start(input bit s);
        if (s) b_start = 1'b1; else start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        b_start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got=%h exp=0", in_ready); end
        n_cmp++; if (im_we !== 4'h0) begin n_bad++; $display("FAIL rst_im_we got=%h exp=0", im_we); end
        n_cmp++; if (im_addr !== 13'h0) begin n_bad++; $display("FAIL rst_im_addr got=%h exp=0", im_addr); end
        n_cmp++; if (im_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_im_wdata got=%h exp=0", im_wdata); end
        n_cmp++; if ({busy, done, error} !== 3'b000) begin n_bad++; $display("FAIL rst_flags got=%b exp=000", {busy, done, error}); end
        n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL rst_cpu_hold got=%h exp=1", cpu_hold); end
        n_cmp++; if (words_written !== 14'd0) begin n_bad++; $display("FAIL rst_words got=%0d exp=0", words_written); end
        rst_n = 1'b1;
        @(negedge clk);
        // Bytes offered in IDLE must be ignored.
        send_word(1'b0, 32'h0000_0001);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy got=%h exp=0", busy); end
        n_cmp++; if (wr_cnt !== 0) begin n_bad++; $display("FAIL idle_writes got=%0d exp=0", wr_cnt); end
    endtask

    task automatic test_nominal(input logic [31:0] s_word, input bit expect_ok);
        // start together with a junk byte: the byte must not be taken as part of N.
        start = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        wr_cnt = 0;
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL nom_ready_len got=%h exp=1", in_ready); end
        n_cmp++; if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL nom_hold_len got=%h exp=1", cpu_hold); end
        send_word(1'b0, 32'd2);
        send_word(1'b0, 32'h3C01_1234);
        n_cmp++; if (im_we !== 4'hF) begin n_bad++; $display("FAIL nom_we0 got=%h exp=f", im_we); end
        n_cmp++; if (im_addr !== 13'd0) begin n_bad++; $display("FAIL nom_addr0 got=%h exp=0", im_addr); end
        n_cmp++; if (im_wdata !== 32'h3C01_1234) begin n_bad++; $display("FAIL nom_wdata0 got=%h exp=3c011234", im_wdata); end
        n_cmp++; if (words_written !== 14'd1) begin n_bad++; $display("FAIL nom_words1 got=%0d exp=1", words_written); end
        send_word(1'b0, 32'h0000_0000);
        n_cmp++; if (im_we !== 4'hF || im_addr !== 13'd1) begin n_bad++; $display("FAIL nom_we1 got=%h/%h exp=f/1", im_we, im_addr); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL nom_busy_sum got=%h exp=1", busy); end
        send_byte(1'b0, s_word[31:24]);
        n_cmp++; if (im_we !== 4'h0) begin n_bad++; $display("FAIL nom_we_pulse got=%h exp=0", im_we); end
        send_byte(1'b0, s_word[23:16]);
        send_byte(1'b0, s_word[15:8]);
        n_cmp++; if (done !== 1'b0 || error !== 1'b0) begin n_bad++; $display("FAIL nom_early got=%b%b exp=00", done, error); end
        send_byte(1'b0, s_word[7:0]);
        n_cmp++; if (wr_cnt !== 2) begin n_bad++; $display("FAIL nom_wr_cnt got=%0d exp=2", wr_cnt); end
        n_cmp++; if (wa[0] !== 13'd0 || wd[0] !== 32'h3C01_1234) begin n_bad++; $display("FAIL nom_log0 got=%h:%h exp=0:3c011234", wa[0], wd[0]); end
        n_cmp++; if (wa[1] !== 13'd1 || wd[1] !== 32'h0) begin n_bad++; $display("FAIL nom_log1 got=%h:%h exp=1:0", wa[1], wd[1]); end
        n_cmp++; if (done !== expect_ok) begin n_bad++; $display("FAIL nom_done got=%h exp=%h", done, expect_ok); end
        n_cmp++; if (error !== !expect_ok) begin n_bad++; $display("FAIL nom_error got=%h exp=%h", error, !expect_ok); end
        n_cmp++; if (cpu_hold !== !expect_ok) begin n_bad++; $display("FAIL nom_hold got=%h exp=%h", cpu_hold, !expect_ok); end
        n_cmp++; if (words_written !== 14'd2) begin n_bad++; $display("FAIL nom_words got=%0d exp=2", words_written); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL nom_ready_end got=%h exp=0", in_ready); end
    endtask

    task automatic test_length_limits;
        pulse_start(1'b1);
        b_wr_cnt = 0;
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h00);
        n_cmp++; if (b_in_ready !== 1'b1) begin n_bad++; $display("FAIL ovf_ready_pre got=%h exp=1", b_in_ready); end
        send_byte(1'b1, 8'h03);
        n_cmp++; if (b_error !== 1'b1) begin n_bad++; $display("FAIL ovf_error got=%h exp=1", b_error); end
        n_cmp++; if (b_in_ready !== 1'b0 || b_busy !== 1'b0) begin n_bad++; $display("FAIL ovf_ready got=%h%h exp=00", b_in_ready, b_busy); end
        n_cmp++; if (b_cpu_hold !== 1'b1) begin n_bad++; $display("FAIL ovf_hold got=%h exp=1", b_cpu_hold); end
        // Near-2^32 count must not wrap into an accepted length.
        pulse_start(1'b1);
        send_word(1'b1, 32'hFFFF_FFFF);
        n_cmp++; if (b_error !== 1'b1 || b_busy !== 1'b0) begin n_bad++; $display("FAIL wrap_error got=%h%h exp=10", b_error, b_busy); end
        n_cmp++; if (b_wr_cnt !== 0) begin n_bad++; $display("FAIL ovf_writes got=%0d exp=0", b_wr_cnt); end
        // Exactly filling the memory is allowed.
        pulse_start(1'b1);
        send_word(1'b1, 32'd2);
        n_cmp++; if (b_busy !== 1'b1 || b_error !== 1'b0) begin n_bad++; $display("FAIL fit_state got=%h%h exp=10", b_busy, b_error); end
        send_word(1'b1, 32'd1);
        send_word(1'b1, 32'd2);
        send_word(1'b1, 32'd3);
        n_cmp++; if (b_done !== 1'b1 || b_cpu_hold !== 1'b0) begin n_bad++; $display("FAIL fit_done got=%h%h exp=10", b_done, b_cpu_hold); end
        n_cmp++; if (b_wr_cnt !== 2) begin n_bad++; $display("FAIL fit_wr_cnt got=%0d exp=2", b_wr_cnt); end
        n_cmp++; if (b_wa[0] !== 13'd8190 || b_wd[0] !== 32'd1) begin n_bad++; $display("FAIL fit_log0 got=%0d:%h exp=8190:1", b_wa[0], b_wd[0]); end
        n_cmp++; if (b_wa[1] !== 13'd8191 || b_wd[1] !== 32'd2) begin n_bad++; $display("FAIL fit_log1 got=%0d:%h exp=8191:2", b_wa[1], b_wd[1]); end
    endtask

    task automatic test_zero_stall;
        logic [63:0] frame;
        frame = 64'h0;
        pulse_start(1'b0);
        wr_cnt = 0;
        for (int i = 7; i >= 0; i--) begin
            send_byte(1'b0, frame[8*i +: 8]);
            if (i == 4) begin
                n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL zero_busy_sum got=%h exp=1", busy); end
            end
            if (i == 1) begin
                n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL zero_done_early got=%h exp=0", done); end
            end
            if (i != 0) @(negedge clk);
        end
        n_cmp++; if (done !== 1'b1 || error !== 1'b0) begin n_bad++; $display("FAIL zero_done got=%h%h exp=10", done, error); end
        n_cmp++; if (wr_cnt !== 0 || words_written !== 14'd0) begin n_bad++; $display("FAIL zero_writes got=%0d/%0d exp=0/0", wr_cnt, words_written); end
    endtask

    task automatic test_reset_midload;
        pulse_start(1'b0);
        send_word(1'b0, 32'd2);
        send_word(1'b0, 32'h1122_3344);
        send_byte(1'b0, 8'h55);
        send_byte(1'b0, 8'h66);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({in_ready, busy, done, error} !== 4'b0000) begin n_bad++; $display("FAIL mid_flags got=%b exp=0000", {in_ready, busy, done, error}); end
        n_cmp++; if (im_we !== 4'h0 || im_addr !== 13'h0 || im_wdata !== 32'h0) begin n_bad++; $display("FAIL mid_port got=%h/%h/%h exp=0/0/0", im_we, im_addr, im_wdata); end
        n_cmp++; if (cpu_hold !== 1'b1 || words_written !== 14'd0) begin n_bad++; $display("FAIL mid_hold got=%h/%0d exp=1/0", cpu_hold, words_written); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start(1'b0);
        wr_cnt = 0;
        send_word(1'b0, 32'd1);
        send_word(1'b0, 32'hDEAD_BEEF);
        send_word(1'b0, 32'hDEAD_BEEF);
        n_cmp++; if (wr_cnt !== 1 || wa[0] !== 13'd0 || wd[0] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL reload_log got=%0d %h:%h exp=1 0:deadbeef", wr_cnt, wa[0], wd[0]); end
        n_cmp++; if (done !== 1'b1 || error !== 1'b0) begin n_bad++; $display("FAIL reload_done got=%h%h exp=10", done, error); end
    endtask

    task automatic test_start_in_data;
        pulse_start(1'b0);
        wr_cnt = 0;
        send_word(1'b0, 32'd2);
        send_word(1'b0, 32'h0000_0005);
        pulse_start(1'b0);
        send_byte(1'b0, 8'h00);
        send_byte(1'b0, 8'h00);
        pulse_start(1'b0);
        send_byte(1'b0, 8'h00);
        send_byte(1'b0, 8'h0A);
        send_word(1'b0, 32'h0000_000F);
        n_cmp++; if (done !== 1'b1 || error !== 1'b0) begin n_bad++; $display("FAIL ign_done got=%h%h exp=10", done, error); end
        n_cmp++; if (words_written !== 14'd2) begin n_bad++; $display("FAIL ign_words got=%0d exp=2", words_written); end
        n_cmp++; if (wr_cnt !== 2 || wa[1] !== 13'd1 || wd[1] !== 32'h0000_000A) begin n_bad++; $display("FAIL ign_log got=%0d %h:%h exp=2 1:a", wr_cnt, wa[1], wd[1]); end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        b_start = 1'b0; b_in_valid = 1'b0; b_in_data = 8'h00;
        @(negedge clk);
        test_reset();
        test_nominal(32'h3C01_1234, 1'b1);
        test_nominal(32'h3C01_1235, 1'b0);
        test_length_limits();
        test_zero_stall();
        test_reset_midload();
        test_start_in_data();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/im_loader.md
# im_loader

Writer side of the instruction memory. It accepts a framed byte stream, typically from the UART receiver, and assembles big-endian 32-bit words. It writes them through the IM block-RAM write port (wea/addra/dina) that the IM read path leaves tied off. The processor is held while a program loads and is released only after a length and checksum check passes.

## Interface
Parameters:
- IM_WORDS, 8192: IM capacity in words; matches the 13-bit word address (byte address bits 14:2).
- LOAD_BASE_WORD, 0: word offset, relative to IM_START_ADDRESS, of the first loaded word.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that arms a load; honoured only in IDLE, DONE or ERR.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- im_we  out  4  RAM byte write enables; 4'b1111 or 4'b0000 only.
- im_addr  out  13  RAM word address.
- im_wdata  out  32  RAM write data.
- busy  out  1  high in LEN, DATA and SUM.
- done  out  1  load verified; sticky.
- error  out  1  load rejected; sticky.
- cpu_hold  out  1  keeps the processor in reset.
- words_written  out  14  count of words written in the current load.

## Operation
- Frame format, all fields big-endian with the first byte in bits 31:24:
  - N, a 4-byte word count;
  - N 4-byte data words;
  - S, a 4-byte checksum equal to the sum of the data words mod 2^32.
- States and transitions:
  - IDLE → LEN on start.
  - LEN → ERR after 4 bytes if LOAD_BASE_WORD + N > IM_WORDS. Compute this sum 33 bits wide; N ≥ 2^32 − LOAD_BASE_WORD must not wrap.
  - LEN → SUM after 4 bytes if N == 0.
  - LEN → DATA after 4 bytes otherwise.
  - DATA → SUM after the N-th word is accepted.
  - SUM → DONE after 4 bytes if S equals the running sum.
  - SUM → ERR after 4 bytes if S differs.
  - DONE or ERR → LEN on start.
- A byte-lane counter (0..3) selects the byte within a word. It resets to 0 on each field boundary and on each entry to LEN.
- Each completed data word is written to im_addr = LOAD_BASE_WORD + word index. The running sum and words_written are updated in the same cycle.
- Entry to LEN clears done, error, words_written and the running sum, and sets cpu_hold.
- Entry to DONE sets done and clears cpu_hold.
- Entry to ERR sets error; cpu_hold stays 1.
- start is ignored in LEN, DATA and SUM.
- in_valid is ignored outside LEN, DATA and SUM.
- RAM contents are never cleared by this block. Words beyond N keep their old values.

## Timing
- Reset values:
  - in_ready, im_we, im_addr, im_wdata, busy, done, error and words_written are 0;
  - cpu_hold is 1;
  - state is IDLE.
- in_ready is combinationally equal to busy. The block accepts one byte per cycle with no back-pressure gaps.
- Write latency: im_we pulses 4'b1111 for exactly one cycle, in the cycle after the 4th byte of a data word is accepted. im_addr and im_wdata are registered and valid in that same cycle.
- Back-to-back words: one write every 4 cycles at full input rate. No write is dropped when in_valid stalls mid-word.
- State updates, all registered and visible the cycle after the last accepted byte:
  - done, error and cpu_hold change the cycle after the last S byte is accepted;
  - the length-error transition to ERR happens the cycle after the last N byte.
- Last data word: its write and the state change to SUM happen in the same cycle.
- start and the first N byte may arrive in the same cycle: start wins and the byte is not accepted (in_ready is still 0).
- Reset mid-load returns every output to its reset value asynchronously. Partial RAM writes remain.

## Structure
- A shared package im_pkg holds:
  - the state enum (IDLE, LEN, DATA, SUM, DONE, ERR);
  - IM_WORDS;
  - the IM word-address width (13);
  - IM_START_ADDRESS, so the loader and the IM reader derive addresses identically.
- One natural sub-module, im_word_packer: the byte-lane counter plus a 32-bit shift register emitting word_valid/word_data. It is reused for the N, data and S fields.
- The FSM, address counter and checksum live in im_loader.

## Test plan
- Nominal load:
  - Stimulus: start, N = 2, words 0x3C011234 and 0x00000000, S = 0x3C011234.
  - Response: writes to addr 0 and 1 with those values; done = 1, error = 0, cpu_hold = 0, words_written = 2.
- Bad checksum:
  - Stimulus: the same frame with S = 0x3C011235.
  - Response: both writes still occur; error = 1, done = 0, cpu_hold = 1.
- Length overflow:
  - Stimulus: LOAD_BASE_WORD = 8190, N = 3.
  - Response: ERR entered the cycle after the 4th N byte; im_we never asserted; in_ready = 0 afterwards.
- Zero-length and stalled input:
  - Stimulus: N = 0 and S = 0, with in_valid toggled 1/0 every cycle.
  - Response: no writes; done = 1 after the 8th accepted byte.
- Reset and ignored start:
  - Stimulus: rst_n pulled low after 6 data bytes, then start, N = 1, word 0xDEADBEEF, S = 0xDEADBEEF. Separately, pulse start during DATA.
  - Response:
    - all outputs return to reset values immediately on rst_n low;
    - the reload writes addr 0 = 0xDEADBEEF and sets done;
    - the start pulse during DATA has no effect.
